// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs a req/ready read on instruction memory
// and hands the fetched opcode plus decoded register/function fields to the main controller.
`ifndef INSTR_OPCODE_WIDTH
`define INSTR_OPCODE_WIDTH 7
`endif

module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_req,
  input  logic                           pc_write,
  input  logic [XLEN-1:0]                pc_next,
  input  logic                           pc_inc,
  output logic                           mem_req,
  output logic [XLEN-1:0]                mem_addr,
  input  logic                           mem_ready,
  input  logic [31:0]                    mem_rdata,
  output logic [`INSTR_OPCODE_WIDTH-1:0] opCode,
  output logic [4:0]                     rd,
  output logic [2:0]                     funct3,
  output logic [4:0]                     rs1,
  output logic [4:0]                     rs2,
  output logic [6:0]                     funct7,
  output logic [31:0]                    instr,
  output logic [XLEN-1:0]                pc,
  output logic                           instr_valid,
  output logic                           busy,
  output logic                           fault
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(32'd4);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

  state_t            state_r, state_nxt_s;
  logic              mem_req_r, mem_req_nxt_s;
  logic [XLEN-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [31:0]       ir_r, ir_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              fault_r, fault_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [XLEN-1:0]   pc_r;

  // Next-state and next-register values for the fetch handshake
  always_comb begin
    state_nxt_s    = state_r;
    mem_req_nxt_s  = mem_req_r;
    mem_addr_nxt_s = mem_addr_r;
    ir_nxt_s       = ir_r;
    cnt_nxt_s      = cnt_r;
    fault_nxt_s    = fault_r;
    valid_nxt_s    = 1'b0;
    busy_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fetch_req || fault_r) begin
          state_nxt_s = ST_IDLE;
        end else if (is_aligned(pc_r[1:0])) begin
          mem_addr_nxt_s = pc_r;
          mem_req_nxt_s  = 1'b1;
          cnt_nxt_s      = CNT_ZERO;
          state_nxt_s    = ST_WAIT;
        end else begin
          fault_nxt_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          ir_nxt_s      = mem_rdata;
          mem_req_nxt_s = 1'b0;
          cnt_nxt_s     = CNT_ZERO;
          state_nxt_s   = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          // Memory never answered: give up, leave IR untouched
          fault_nxt_s   = 1'b1;
          mem_req_nxt_s = 1'b0;
          cnt_nxt_s     = CNT_ZERO;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        valid_nxt_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        mem_req_nxt_s = 1'b0;
        cnt_nxt_s     = CNT_ZERO;
        state_nxt_s   = ST_IDLE;
      end
    endcase
    if ((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_DONE)) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // Fetch state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= {XLEN{1'b0}};
      ir_r       <= NOP_INSTR;
      cnt_r      <= CNT_ZERO;
      fault_r    <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      mem_req_r  <= mem_req_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      ir_r       <= ir_nxt_s;
      cnt_r      <= cnt_nxt_s;
      fault_r    <= fault_nxt_s;
      valid_r    <= valid_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // PC updates are independent of the fetch state; mem_addr holds the in-flight address
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (pc_write) begin
      pc_r <= pc_next;
    end else if (pc_inc) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr       = ir_r;
  assign opCode      = ir_r[`INSTR_OPCODE_WIDTH-1:0];
  assign rd          = ir_r[11:7];
  assign funct3      = ir_r[14:12];
  assign rs1         = ir_r[19:15];
  assign rs2         = ir_r[24:20];
  assign funct7      = ir_r[31:25];
  assign pc          = pc_r;
  assign instr_valid = valid_r;
  assign busy        = busy_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected instruction words are queued when memory
// data is driven and compared, with latency and decoded fields, when instr_valid pulses.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        pc_inc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [6:0]  opCode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        busy;
  logic        fault;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          req_cyc = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_write(pc_write), .pc_next(pc_next),
    .pc_inc(pc_inc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .opCode(opCode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .instr(instr), .pc(pc), .instr_valid(instr_valid), .busy(busy),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue fetch_req for one edge and remember the request cycle
  task automatic start_fetch();
    fetch_req = 1'b1;
    tick();
    req_cyc   = cyc;
    fetch_req = 1'b0;
  endtask

  // Wait for instr_valid (bounded), then pop the scoreboard and compare everything
  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    logic [31:0] e;
    while (instr_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    if (instr_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_lat"},    32'(cyc - req_cyc), 32'(exp_lat));
      check({tag, "_instr"},  instr,              e);
      check({tag, "_opcode"}, 32'(opCode),        32'(e[6:0]));
      check({tag, "_rd"},     32'(rd),            32'(e[11:7]));
      check({tag, "_funct3"}, 32'(funct3),        32'(e[14:12]));
      check({tag, "_rs1"},    32'(rs1),           32'(e[19:15]));
      check({tag, "_rs2"},    32'(rs2),           32'(e[24:20]));
      check({tag, "_funct7"}, 32'(funct7),        32'(e[31:25]));
      tick();
      check({tag, "_pulse1"}, 32'(instr_valid),   32'd0);
      check({tag, "_idle"},   32'(busy),          32'd0);
    end else begin
      check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; fetch_req = 1'b0; pc_write = 1'b0; pc_next = 32'h0; pc_inc = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // T1 reset
    tick(); tick();
    check("t1_pc",      pc,               32'h0);
    check("t1_instr",   instr,            32'h0000_0013);
    check("t1_opcode",  32'(opCode),      32'h13);
    check("t1_mem_req", 32'(mem_req),     32'd0);
    check("t1_addr",    mem_addr,         32'h0);
    check("t1_fault",   32'(fault),       32'd0);
    check("t1_busy",    32'(busy),        32'd0);
    check("t1_valid",   32'(instr_valid), 32'd0);
    rst = 1'b0;
    tick();

    // T2 zero-wait fetch
    start_fetch();
    check("t2_mem_req", 32'(mem_req), 32'd1);
    check("t2_addr",    mem_addr,     32'h0);
    check("t2_busy",    32'(busy),    32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093; exp_q.push_back(32'h0050_0093);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("t2_req_drop", 32'(mem_req), 32'd0);
    wait_valid("t2", 2);
    check("t2_rd1",  32'(rd),  32'd1);
    check("t2_rs1",  32'(rs1), 32'd0);

    // mem_ready while idle must not touch IR
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    mem_ready = 1'b0;
    check("idle_ready_instr", instr,             32'h0050_0093);
    check("idle_ready_valid", 32'(instr_valid),  32'd0);

    // T3 three wait states, pc_inc during WAIT
    start_fetch();
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("t3_pc",    pc,            32'h4);
    check("t3_addr1", mem_addr,      32'h0);
    check("t3_req1",  32'(mem_req),  32'd1);
    tick();
    check("t3_addr2", mem_addr,      32'h0);
    check("t3_req2",  32'(mem_req),  32'd1);
    tick();
    check("t3_addr3", mem_addr,      32'h0);
    check("t3_req3",  32'(mem_req),  32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h00A2_8313; exp_q.push_back(32'h00A2_8313);
    tick();
    mem_ready = 1'b0;
    wait_valid("t3", 5);
    check("t3_pc_after", pc, 32'h4);

    // T4 pc control
    pc_write = 1'b1; pc_next = 32'h100; pc_inc = 1'b1;
    tick();
    pc_write = 1'b0; pc_inc = 1'b0;
    check("t4_pc_prio", pc, 32'h100);
    start_fetch();
    check("t4_addr", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'h40B5_0533; exp_q.push_back(32'h40B5_0533);
    tick();
    mem_ready = 1'b0;
    wait_valid("t4", 2);
    pc_write = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick();
    pc_write = 1'b0; pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("t4_wrap", pc, 32'h0);

    // T5 misaligned PC fault
    pc_write = 1'b1; pc_next = 32'h2;
    tick();
    pc_write = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t5_mis_fault", 32'(fault),   32'd1);
    check("t5_mis_req",   32'(mem_req), 32'd0);
    tick();
    check("t5_mis_req2",  32'(mem_req), 32'd0);

    // T5 timeout after a fresh reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("t5_rst_fault", 32'(fault), 32'd0);
    start_fetch();
    n = (mem_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      check("t5_to_addr", mem_addr, 32'h0);
      tick();
      if (mem_req === 1'b1) n++;
    end
    check("t5_to_cycles", 32'(n),           32'd16);
    check("t5_to_fault",  32'(fault),       32'd1);
    check("t5_to_instr",  instr,            32'h0000_0013);
    check("t5_to_valid",  32'(instr_valid), 32'd0);
    fetch_req = 1'b1;
    tick(); tick();
    fetch_req = 1'b0;
    check("t5_ignored_req",  32'(mem_req), 32'd0);
    check("t5_ignored_busy", 32'(busy),    32'd0);

    // T6 reset in the middle of WAIT after a successful fetch
    rst = 1'b1; tick(); rst = 1'b0;
    start_fetch();
    mem_ready = 1'b1; mem_rdata = 32'h0010_0073; exp_q.push_back(32'h0010_0073);
    tick();
    mem_ready = 1'b0;
    wait_valid("t6pre", 2);
    start_fetch();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_req",   32'(mem_req), 32'd0);
    check("t6_busy",  32'(busy),    32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t6_valid1", 32'(instr_valid), 32'd0);
    tick();
    mem_ready = 1'b0;
    check("t6_instr",  instr,            32'h0000_0013);
    check("t6_valid2", 32'(instr_valid), 32'd0);
    check("t6_req2",   32'(mem_req),     32'd0);
    check("sb_empty",  32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
